// File: rtl/decode.sv
// Instruction decode stage: register file with write-through bypass,
// opcode/funct decode, hazard detection, branch/jump resolution and the
// ID/EX pipeline register.
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir_i,
  input  logic [31:0] npc_i,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  output logic        pc_update,
  output logic [31:0] pc_i,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_alusrc,
  output logic [2:0]  ex_aluop,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_npc
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic [2:0]  aluop;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] npc;
  } id_ex_t;

  id_ex_t      id_ex_reg;
  id_ex_t      id_ex_next;
  logic [31:0] rf_reg [32];

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd_field;
  logic [5:0]  funct;
  logic [31:0] imm_sext;

  assign opcode   = ir_i[31:26];
  assign rs       = ir_i[25:21];
  assign rt       = ir_i[20:16];
  assign rd_field = ir_i[15:11];
  assign funct    = ir_i[5:0];
  assign imm_sext = {{16{ir_i[15]}}, ir_i[15:0]};

  // Register file: cleared by reset, r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      rf_reg[wb_addr] <= wb_data;
    end
  end

  // Read ports; a same-cycle writeback to the addressed register wins.
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (wb_we && wb_addr == rs) ? wb_data : rf_reg[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (wb_we && wb_addr == rt) ? wb_data : rf_reg[rt];

  // Decode: classify the instruction and derive EX controls.
  logic       dec_issue;
  logic       dec_regwrite;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_alusrc;
  logic [2:0] dec_aluop;
  logic [4:0] dec_rd;
  logic       is_beq;
  logic       is_bne;
  logic       is_j;
  logic       use_rs;
  logic       use_rt;

  always_comb begin
    dec_issue    = 1'b0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_alusrc   = 1'b0;
    dec_aluop    = 3'd0;
    dec_rd       = 5'd0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_j         = 1'b0;
    use_rs       = 1'b0;
    use_rt       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_issue = 1'b1;
        case (funct)
          6'h20:   dec_aluop = 3'd0;
          6'h22:   dec_aluop = 3'd1;
          6'h24:   dec_aluop = 3'd2;
          6'h25:   dec_aluop = 3'd3;
          6'h2A:   dec_aluop = 3'd4;
          default: dec_issue = 1'b0;
        endcase
        dec_regwrite = dec_issue;
        dec_rd       = dec_issue ? rd_field : 5'd0;
        use_rs       = dec_issue;
        use_rt       = dec_issue;
      end
      OP_ADDI: begin
        dec_issue    = 1'b1;
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_rd       = rt;
        use_rs       = 1'b1;
      end
      OP_LW: begin
        dec_issue    = 1'b1;
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
        dec_alusrc   = 1'b1;
        dec_rd       = rt;
        use_rs       = 1'b1;
      end
      OP_SW: begin
        dec_issue    = 1'b1;
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
      end
      OP_BEQ: begin
        is_beq = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  // Hazards: load-use against EX, and branch operands not yet in the file.
  logic is_branch;
  logic load_use;
  logic rs_pending;
  logic rt_pending;
  logic branch_haz;
  logic stall;

  assign is_branch = is_beq | is_bne;
  assign load_use  = id_ex_reg.valid && id_ex_reg.memread && id_ex_reg.rd != 5'd0 &&
                     ((use_rs && rs == id_ex_reg.rd) || (use_rt && rt == id_ex_reg.rd));
  assign rs_pending = rs != 5'd0 &&
                      ((id_ex_reg.valid && id_ex_reg.regwrite && rs == id_ex_reg.rd) ||
                       (mem_regwrite && rs == mem_rd));
  assign rt_pending = rt != 5'd0 &&
                      ((id_ex_reg.valid && id_ex_reg.regwrite && rt == id_ex_reg.rd) ||
                       (mem_regwrite && rt == mem_rd));
  assign branch_haz = is_branch && (rs_pending || rt_pending);
  assign stall      = load_use || branch_haz;

  // Control-flow resolution
  logic        regs_equal;
  logic        taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign regs_equal    = (rs_val == rt_val);
  assign taken         = is_j || (is_beq && regs_equal) || (is_bne && !regs_equal);
  assign branch_target = npc_i + imm_sext;
  assign jump_target   = {npc_i[31:26], ir_i[25:0]};

  // Fetch redirect: stall replays the current word, otherwise follow a taken transfer.
  always_comb begin
    pc_update = 1'b0;
    pc_i      = 32'd0;
    if (!rst) begin
      if (stall) begin
        pc_update = 1'b1;
        pc_i      = npc_i - 32'd1;
      end else if (taken) begin
        pc_update = 1'b1;
        pc_i      = is_j ? jump_target : branch_target;
      end
    end
  end

  // Next ID/EX contents; stalls, transfers and unknown words become bubbles.
  always_comb begin
    id_ex_next = '0;
    if (dec_issue && !stall) begin
      id_ex_next.valid    = 1'b1;
      id_ex_next.regwrite = dec_regwrite;
      id_ex_next.memread  = dec_memread;
      id_ex_next.memwrite = dec_memwrite;
      id_ex_next.alusrc   = dec_alusrc;
      id_ex_next.aluop    = dec_aluop;
      id_ex_next.rs_val   = rs_val;
      id_ex_next.rt_val   = rt_val;
      id_ex_next.imm      = imm_sext;
      id_ex_next.rs       = rs;
      id_ex_next.rt       = rt;
      id_ex_next.rd       = dec_rd;
      id_ex_next.npc      = npc_i;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) id_ex_reg <= '0;
    else     id_ex_reg <= id_ex_next;
  end

  assign ex_valid    = id_ex_reg.valid;
  assign ex_regwrite = id_ex_reg.regwrite;
  assign ex_memread  = id_ex_reg.memread;
  assign ex_memwrite = id_ex_reg.memwrite;
  assign ex_alusrc   = id_ex_reg.alusrc;
  assign ex_aluop    = id_ex_reg.aluop;
  assign ex_rs_val   = id_ex_reg.rs_val;
  assign ex_rt_val   = id_ex_reg.rt_val;
  assign ex_imm      = id_ex_reg.imm;
  assign ex_rs       = id_ex_reg.rs;
  assign ex_rt       = id_ex_reg.rt;
  assign ex_rd       = id_ex_reg.rd;
  assign ex_npc      = id_ex_reg.npc;

endmodule
